// File: rtl/trigger_scaler_accum.sv
// trigger_scaler_accum: gated per-channel scaler pulse counters that snapshot once per period,
// with a registered, addressed read port into the snapshot bank.
module trigger_scaler_accum #(
  parameter int NSCAL  = 46,
  parameter int CNT_W  = 16,
  parameter int PERIOD = 100000000,
  parameter int SEL_W  = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [NSCAL-1:0] scaler_i,
  input  logic             hold_i,
  input  logic [SEL_W-1:0] sel_i,
  output logic [CNT_W-1:0] dat_o,
  output logic             update_o,
  output logic             skipped_o
);
  localparam int GW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  logic [GW-1:0]    r_gate;
  logic [NSCAL-1:0] r_prev;
  logic [NSCAL-1:0] w_edge;
  logic [CNT_W-1:0] r_acc  [NSCAL];
  logic [CNT_W-1:0] r_snap [NSCAL];
  logic [CNT_W-1:0] w_next [NSCAL];
  logic             w_term;
  assign w_edge = scaler_i & ~r_prev;
  assign w_term = r_gate == GW'(PERIOD - 1);
  // saturating increment; an edge on the term cycle still belongs to the closing period
  always_comb
    for (int k = 0; k < NSCAL; k++)
      w_next[k] = (w_edge[k] && r_acc[k] != '1) ? r_acc[k] + 1'b1 : r_acc[k];
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      r_gate    <= '0;
      r_prev    <= '0;
      dat_o     <= '0;
      update_o  <= 1'b0;
      skipped_o <= 1'b0;
      for (int k = 0; k < NSCAL; k++) begin
        r_acc[k]  <= '0;
        r_snap[k] <= '0;
      end
    end else begin
      r_gate    <= w_term ? '0 : r_gate + 1'b1;
      r_prev    <= scaler_i;
      update_o  <= w_term & ~hold_i;
      skipped_o <= w_term ? hold_i : skipped_o;
      dat_o     <= (int'(sel_i) < NSCAL) ? r_snap[sel_i] : '0;
      for (int k = 0; k < NSCAL; k++) begin
        r_acc[k] <= w_term ? '0 : w_next[k];
        if (w_term && !hold_i) r_snap[k] <= w_next[k];
      end
    end
endmodule

// File: tb/tb_trigger_scaler_accum.sv
// tb_trigger_scaler_accum: directed bench for trigger_scaler_accum; a narrow second instance
// exercises counter saturation within a short run.
module tb_trigger_scaler_accum;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [45:0] sc = '0;
  logic [45:0] ss = '0;
  logic        hold = 1'b0;
  logic [5:0]  sel = '0;
  logic [5:0]  sel_s = '0;
  logic [15:0] dat;
  logic [7:0]  dat_s;
  logic        upd, skp, upd_s, skp_s;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  bit          sat_en = 1'b0;

  trigger_scaler_accum #(.NSCAL(46), .CNT_W(16), .PERIOD(100), .SEL_W(6)) dut (
    .clk_i(clk), .rst_i(rst), .scaler_i(sc), .hold_i(hold), .sel_i(sel),
    .dat_o(dat), .update_o(upd), .skipped_o(skp));

  trigger_scaler_accum #(.NSCAL(46), .CNT_W(8), .PERIOD(600), .SEL_W(6)) dut_s (
    .clk_i(clk), .rst_i(rst), .scaler_i(ss), .hold_i(1'b0), .sel_i(sel_s),
    .dat_o(dat_s), .update_o(upd_s), .skipped_o(skp_s));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    ss[0] = sat_en && cyc < 600 && (cyc % 2 == 0);
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) tick();
  endtask

  task automatic pulse(input int k);
    sc[k] = 1'b1;
    tick();
    sc[k] = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    tick();
    tick();
    chk("rst_dat", dat, 0);
    chk("rst_upd", upd, 0);
    chk("rst_skp", skp, 0);
    chk("rst_dat_s", dat_s, 0);
    rst = 1'b0;
    cyc = 0;
    sat_en = 1'b1;
    ss[0] = 1'b1;
    // idle periods: update at 100, 200, 300
    wait_to(99);  chk("upd_99", upd, 0);
    tick();       chk("upd_100", upd, 1); chk("skp_100", skp, 0);
    tick();       chk("upd_101", upd, 0);
    wait_to(199); chk("upd_199", upd, 0);
    tick();       chk("upd_200", upd, 1);
    wait_to(210);
    foreach (sc[k]) if (k == 0 || k == 3 || k == 20 || k == 44 || k == 45) begin
      sel = 6'(k);
      tick();
      chk("idle_read", dat, 0);
    end
    sel = 6'd63; tick(); chk("idle_read_oor", dat, 0);
    wait_to(300); chk("upd_300", upd, 1); chk("skp_300", skp, 0);
    // ch3: ten single-cycle pulses in period 301..400
    for (int i = 0; i < 10; i++) begin
      wait_to(300 + 10 * i);
      pulse(3);
    end
    wait_to(399); sel = 6'd3;
    tick(); chk("ch3_upd", upd, 1); chk("ch3_old", dat, 0);
    tick(); chk("ch3_new", dat, 10);
    sel = 6'd4; tick(); chk("ch4_zero", dat, 0);
    // ch20: high 50, low 1, high 1
    wait_to(405); sc[20] = 1'b1;
    repeat (50) tick();
    sc[20] = 1'b0; tick();
    sc[20] = 1'b1; tick();
    sc[20] = 1'b0;
    wait_to(500); sel = 6'd20;
    tick(); chk("ch20", dat, 2);
    sel = 6'd3; tick(); chk("ch3_cleared", dat, 0);
    // ch44 edge on term cycle
    wait_to(599); pulse(44);
    chk("t44_upd", upd, 1);
    chk("sat_upd", upd_s, 1);
    sel = 6'd44;
    tick(); chk("ch44_term", dat, 1); chk("sat_ch0", dat_s, 8'hff);
    sat_en = 1'b0;
    wait_to(700); chk("t44_upd2", upd, 1);
    tick(); chk("ch44_next", dat, 0);
    // ch5 = 7, with a hold glitch away from the term cycle
    for (int i = 0; i < 7; i++) begin
      wait_to(710 + 2 * i);
      pulse(5);
    end
    wait_to(750); hold = 1'b1; tick(); hold = 1'b0;
    wait_to(799); sel = 6'd5;
    tick(); chk("ch5_upd", upd, 1); chk("ch5_skp0", skp, 0);
    tick(); chk("ch5_7", dat, 7);
    // held period: 3 pulses discarded, snapshot suppressed
    for (int i = 0; i < 3; i++) begin
      wait_to(810 + 2 * i);
      pulse(5);
    end
    wait_to(850); hold = 1'b1;
    wait_to(900); chk("hold_upd", upd, 0); chk("hold_skp", skp, 1);
    tick(); chk("hold_dat", dat, 7);
    hold = 1'b0;
    for (int i = 0; i < 2; i++) begin
      wait_to(910 + 2 * i);
      pulse(5);
    end
    wait_to(950); chk("skp_sticky", skp, 1);
    wait_to(1000); chk("rel_upd", upd, 1); chk("rel_skp", skp, 0);
    tick(); chk("ch5_2", dat, 2);
    sel = 6'd50; tick(); chk("oor_50", dat, 0);
    sel = 6'd5;  tick(); chk("ch5_again", dat, 2);
    // set skipped again, then reset mid-period with partial counts pending
    wait_to(1090); hold = 1'b1;
    wait_to(1100); chk("skp_set2", skp, 1);
    tick(); hold = 1'b0;
    wait_to(1120); pulse(5);
    wait_to(1122); pulse(5);
    wait_to(1150); rst = 1'b1;
    #1;
    chk("arst_dat", dat, 0);
    chk("arst_skp", skp, 0);
    chk("arst_upd", upd, 0);
    tick(); tick();
    rst = 1'b0;
    cyc = 0;
    wait_to(99); chk("rr_upd_99", upd, 0);
    tick(); chk("rr_upd_100", upd, 1);
    tick(); chk("rr_ch5", dat, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
